fp_argmin: RTL and testbench

Streaming single-precision minimum finder: accepts a frame of IEEE-754 binary32 values over a valid/ready stream and returns the smallest value and its position in the frame. It is the less-than counterpart of the floating-point greater-than comparator. It sits in the floating library next to the other comparison primitives and feeds sort and threshold logic downstream. It uses the same ordering rules as the comparator: sign, then exponent, then mantissa with an implied leading 1, with no special NaN, infinity or denormal handling.

---
 rtl/fp_argmin.sv | 101 ++++++++++
 tb/tb_fp_argmin.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_argmin.sv
// rtl/fp_argmin.sv - streaming binary32 minimum finder returning value and first index

module fp_argmin #(
    parameter int IDXW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_min,
    output logic [IDXW-1:0] out_idx,
    output logic            out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state;
    logic [31:0]       cur_min;
    logic [IDXW-1:0]   cur_idx;
    logic [IDXW-1:0]   cnt;
    logic              ovf;

    // The implied leading 1 is common to both operands, so exponent-then-mantissa
    // ordering reduces to an unsigned compare of the low 31 bits.
    function automatic logic lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31];
        else if (a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    assign out_min = cur_min;
    assign out_idx = cur_idx;
    assign out_ovf = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cur_min   <= '0;
            cur_idx   <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_min <= in_data;
                        cur_idx <= '0;
                        cnt     <= IDXW'(1);
                        ovf     <= 1'b0;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        if (lt(in_data, cur_min)) begin
                            cur_min <= in_data;
                            cur_idx <= cnt;
                        end
                        cnt <= cnt + IDXW'(1);
                        // cnt of zero here means the counter has wrapped past 2^IDXW elements
                        if (cnt == '0)
                            ovf <= 1'b1;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_argmin.sv
// tb/tb_fp_argmin.sv - self-checking bench for fp_argmin with vector table and random frames

module tb_fp_argmin;

    localparam int IDXW = 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_min;
    logic [IDXW-1:0] out_idx;
    logic            out_ovf;

    fp_argmin #(.IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min   (out_min),
        .out_idx   (out_idx),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int              n;
        logic [0:4][31:0] d;
        logic [31:0]     exp_min;
        int              exp_idx;
        bit              exp_ovf;
    } vec_t;

    vec_t        vecs [0:5];
    logic [31:0] fd [0:7];
    int          fn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Total-order key: positive magnitudes map upward, negatives map below -1 in reverse.
    function automatic longint key(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:23]) * 64'd16777216 + 64'd8388608 + longint'(v[22:0]);
        return v[31] ? (-64'sd1 - mag) : mag;
    endfunction

    function automatic void model(input int n, output logic [31:0] m, output int idx, output bit ov);
        int best;
        best = 0;
        for (int i = 1; i < n; i++)
            if (key(fd[i]) < key(fd[best])) best = i;
        m   = fd[best];
        idx = best % (1 << IDXW);
        ov  = (n > (1 << IDXW));
    endfunction

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            check("in_ready_during_frame", 32'(in_ready), 32'd1);
            check("out_valid_during_frame", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = fd[i];
            in_last  = (i == n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        check("out_valid_latency", 32'(out_valid), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] m, input int idx, input bit ov);
        check({tag, "_min"}, out_min, m);
        check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(ov));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    task automatic set_vec(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] e,
                           input logic [31:0] m, input int idx, input bit ov);
        vecs[k].n       = n;
        vecs[k].d       = {a, b, c, d, e};
        vecs[k].exp_min = m;
        vecs[k].exp_idx = idx;
        vecs[k].exp_ovf = ov;
    endtask

    initial begin
        logic [31:0] em;
        int          ei;
        bit          eo;
        logic [31:0] pool [0:5];

        set_vec(0, 4, 32'h40400000, 32'hBFC00000, 32'h40000000, 32'hBFC00000, 32'h0,
                32'hBFC00000, 1, 1'b0);
        set_vec(1, 3, 32'hC0000000, 32'hBF800000, 32'hC0400000, 32'h0, 32'h0,
                32'hC0400000, 2, 1'b0);
        set_vec(2, 2, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h0,
                32'h80000000, 1, 1'b0);
        set_vec(3, 1, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h3F800000, 0, 1'b0);
        set_vec(4, 5, 32'h40000000, 32'hBF800000, 32'h3F000000, 32'hC0000000, 32'hC1200000,
                32'hC1200000, 0, 1'b1);
        set_vec(5, 3, 32'h41000000, 32'h40A00000, 32'h40A00000, 32'h0, 32'h0,
                32'h40A00000, 1, 1'b0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hDEADBEEF;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_result("rst", 32'h0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < vecs[k].n; i++) fd[i] = vecs[k].d[i];
            send_frame(vecs[k].n, 1'b0);
            check_result($sformatf("vec%0d", k), vecs[k].exp_min, vecs[k].exp_idx, vecs[k].exp_ovf);
            handshake();
        end

        // Backpressure: result and in_ready must hold while out_ready is low
        fd[0] = 32'h3F000000; fd[1] = 32'hBE800000; fd[2] = 32'h3E000000;
        send_frame(3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check_result("bp", 32'hBE800000, 1, 1'b0);
        end
        handshake();

        // Asynchronous reset in the middle of a frame
        fd[0] = 32'hC2000000; fd[1] = 32'h41000000;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = fd[i];
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_result("mid_rst", 32'h0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fd[0] = 32'h40800000; fd[1] = 32'h3F800000; fd[2] = 32'h40000000;
        send_frame(3, 1'b0);
        check_result("post_rst", 32'h3F800000, 1, 1'b0);
        handshake();

        pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h3F800000;
        pool[3] = 32'hBF800000; pool[4] = 32'h7F800000; pool[5] = 32'hFF800000;
        for (int f = 0; f < 60; f++) begin
            fn = $urandom_range(1, 7);
            for (int i = 0; i < fn; i++)
                fd[i] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            model(fn, em, ei, eo);
            send_frame(fn, 1'b1);
            check_result("rand", em, ei, eo);
            if ($urandom_range(0, 1) == 1) begin
                for (int c = 0; c < int'($urandom_range(1, 3)); c++) @(negedge clk);
                check_result("rand_hold", em, ei, eo);
            end
            handshake();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
